// File: rtl/wb_mux_pkg.sv
// wb_mux_pkg: shared state encoding, default error data and counter sizing for wb_slave_mux
package wb_mux_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/wb_mux_timeout.sv
// wb_mux_timeout: saturating response-wait counter with load-to-one, clear and expire flag
module wb_mux_timeout #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire_o = cnt_q == W'(LIMIT);
  always_comb cnt_d = clr_i ? '0 : load_i ? W'(1) : (en_i & !expire_o) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: Wishbone-classic slave decoder with timeout watchdog and registered error response.
// Define WB_MUX_STATS_EN to add the err_cnt_o / err_adr_o error statistics ports.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int          N_SLV    = 4,
  parameter int          SEL_LSB  = 14,
  parameter int          SEL_W    = 2,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [N_SLV-1:0]   s_cyc_o,
  output logic [N_SLV-1:0]   s_stb_o,
  input  logic [N_SLV-1:0]   s_ack_i,
  input  logic [N_SLV*32-1:0] s_dat_i
`ifdef WB_MUX_STATS_EN
  ,
  output logic [15:0]        err_cnt_o,
  output logic [31:0]        err_adr_o
`endif
);
  localparam int CW = cnt_w(TIMEOUT);
  state_e state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d, sel, cur;
  logic req, valid, go, ack_s, expire, load, clr, en, unused_adr;
  logic [31:0] dat_s;
  logic [N_SLV-1:0] onehot;
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign sel        = wbs_adr_i[SEL_LSB +: SEL_W];
  assign valid      = int'(sel) < N_SLV;
  assign cur        = (state_q == BUSY) ? slot_q : sel;
  assign unused_adr = ^wbs_adr_i;
  // reset gates the combinational strobe/ack path so outputs drop the instant rst rises
  assign go = !wb_rst_i & req & ((state_q == BUSY) | ((state_q == IDLE) & valid));
  always_comb begin
    ack_s  = 1'b0;
    dat_s  = '0;
    onehot = '0;
    for (int k = 0; k < N_SLV; k++)
      if (cur == SEL_W'(k)) begin
        ack_s     = s_ack_i[k];
        dat_s     = s_dat_i[32*k +: 32];
        onehot[k] = 1'b1;
      end
  end
  assign s_stb_o   = go ? onehot : '0;
  assign s_cyc_o   = go ? onehot : '0;
  assign wbs_ack_o = (state_q == ERR) | (go & ack_s);
  assign wbs_dat_o = (state_q == ERR) ? ERR_DATA : (go & ack_s) ? dat_s : '0;
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      IDLE:
        if (req & !valid) state_d = ERR;
        else if (go & !ack_s) begin
          state_d = BUSY;
          slot_d  = sel;
        end
      BUSY:    state_d = (!req | ack_s) ? IDLE : expire ? ERR : BUSY;
      default: state_d = IDLE;
    endcase
  end
  assign load = (state_q == IDLE) & go & !ack_s;
  assign clr  = (state_q == BUSY) & (state_d != BUSY);
  assign en   = (state_q == BUSY) & (state_d == BUSY);
  wb_mux_timeout #(.W(CW), .LIMIT(TIMEOUT)) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (clr),
    .load_i   (load),
    .en_i     (en),
    .expire_o (expire)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
`ifdef WB_MUX_STATS_EN
  logic [15:0] err_cnt_q;
  logic [31:0] err_adr_q;
  logic        err_entry;
  assign err_entry = (state_d == ERR) & (state_q != ERR);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else if (err_entry) begin
      err_cnt_q <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + 16'd1;
      err_adr_q <= wbs_adr_i;
    end
  assign err_cnt_o = err_cnt_q;
  assign err_adr_o = err_adr_q;
`endif
endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed checks of decode, zero-wait, timeout, miss, abort and reset for wb_slave_mux
module tb_wb_slave_mux;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0;
  logic [31:0] adr = '0;
  logic ack;
  logic [31:0] dat;
  logic [N-1:0] scyc, sstb, sack;
  logic [N-1:0] extra = '0;
  logic [N*32-1:0] sdat;
  int lat [N];
  int total = 0, bad = 0;
`ifdef WB_MUX_STATS_EN
  logic [15:0] ecnt;
  logic [31:0] eadr;
`endif
  always #5 clk = ~clk;
  // slave k acks after lat[k] strobed cycles (0 = same cycle); extra[k] forces an ack
  for (genvar k = 0; k < N; k++) begin : g_s
    int w = 0;
    assign sdat[32*k +: 32] = 32'(32'h1111_0000 * (k + 1));
    assign sack[k] = (sstb[k] && w == lat[k]) || extra[k];
    always @(posedge clk) w <= (sstb[k] && !sack[k]) ? w + 1 : 0;
  end
  wb_slave_mux #(.N_SLV(N), .SEL_LSB(14), .SEL_W(2), .TIMEOUT(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat),
    .s_cyc_o   (scyc),
    .s_stb_o   (sstb),
    .s_ack_i   (sack),
    .s_dat_i   (sdat)
`ifdef WB_MUX_STATS_EN
    ,
    .err_cnt_o (ecnt),
    .err_adr_o (eadr)
`endif
  );

  task automatic run(input logic [31:0] a, output int n, output logic [31:0] d,
                     output int sc, output logic [N-1:0] so, output logic got);
    cyc = 1'b1; stb = 1'b1; adr = a;
    n = 0; sc = 0; so = '0; got = 1'b0; d = '0;
    while (n < 40 && !got) begin
      #1;
      n++;
      if (sstb != '0) sc++;
      so |= sstb;
      if (ack) begin got = 1'b1; d = dat; end
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc = 1'b1; stb = 1'b1; adr = 32'h0000_4000;
    #12;
    total++;
    if ({sstb, scyc, ack, dat} !== '0) begin
      bad++; $display("FAIL reset_outputs stb=%b cyc=%b ack=%b dat=%h exp all zero", sstb, scyc, ack, dat);
    end
`ifdef WB_MUX_STATS_EN
    total++;
    if (ecnt !== 16'd0 || eadr !== 32'd0) begin
      bad++; $display("FAIL reset_stats cnt=%h adr=%h exp 0", ecnt, eadr);
    end
`endif
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int n, sc; logic [31:0] d; logic [N-1:0] so; logic got;
    lat[1] = 3;
    run(32'h0000_4000, n, d, sc, so, got);
    total++;
    if (!got || n != 4 || sc != 4 || so !== 3'b010) begin
      bad++; $display("FAIL read_s1_timing got=%b cyc=%0d stbcyc=%0d stb=%b exp 1/4/4/010", got, n, sc, so);
    end
    total++;
    if (d !== 32'h2222_0000) begin
      bad++; $display("FAIL read_s1_data got=%h exp=22220000", d);
    end
    cyc = 1'b0; stb = 1'b0;
    #1;
    total++;
    if (ack !== 1'b0 || dat !== 32'd0) begin
      bad++; $display("FAIL read_no_extra_ack ack=%b dat=%h exp 0", ack, dat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n0, n1, n2, sc; logic [31:0] d0, d1, d2; logic [N-1:0] so; logic g0, g1, g2;
    lat[0] = 0; lat[2] = 0;
    run(32'h0000_0000, n0, d0, sc, so, g0);
    run(32'h0000_8000, n1, d1, sc, so, g1);
    run(32'h0000_0000, n2, d2, sc, so, g2);
    go_idle();
    total++;
    if (!(g0 && g1 && g2) || n0 + n1 + n2 != 3) begin
      bad++; $display("FAIL b2b_cycles acks=%b%b%b cycles=%0d exp 111/3", g0, g1, g2, n0 + n1 + n2);
    end
    total++;
    if (d0 !== 32'h1111_0000 || d1 !== 32'h3333_0000 || d2 !== 32'h1111_0000) begin
      bad++; $display("FAIL b2b_data got=%h %h %h exp=11110000 33330000 11110000", d0, d1, d2);
    end
  endtask

  task automatic test_timeout();
    int n, sc; logic [31:0] d; logic [N-1:0] so; logic got;
    lat[2] = 1000;
    run(32'h0000_8000, n, d, sc, so, got);
    go_idle();
    total++;
    if (!got || n != 10 || sc != 9 || so !== 3'b100) begin
      bad++; $display("FAIL timeout_timing got=%b cyc=%0d stbcyc=%0d stb=%b exp 1/10/9/100", got, n, sc, so);
    end
    total++;
    if (d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL timeout_data got=%h exp=deadbeef", d);
    end
`ifdef WB_MUX_STATS_EN
    total++;
    if (ecnt !== 16'd1 || eadr !== 32'h0000_8000) begin
      bad++; $display("FAIL timeout_stats cnt=%0d adr=%h exp 1/00008000", ecnt, eadr);
    end
`endif
  endtask

  task automatic test_ack_at_timeout();
    int n, sc; logic [31:0] d; logic [N-1:0] so; logic got;
    lat[2] = 8;
    run(32'h0000_8000, n, d, sc, so, got);
    go_idle();
    total++;
    if (!got || n != 9 || d !== 32'h3333_0000) begin
      bad++; $display("FAIL ack_wins got=%b cyc=%0d dat=%h exp 1/9/33330000", got, n, d);
    end
`ifdef WB_MUX_STATS_EN
    total++;
    if (ecnt !== 16'd1) begin
      bad++; $display("FAIL ack_wins_stats cnt=%0d exp 1", ecnt);
    end
`endif
  endtask

  task automatic test_miss();
    int n, sc; logic [31:0] d; logic [N-1:0] so; logic got;
    run(32'h0000_C000, n, d, sc, so, got);
    go_idle();
    total++;
    if (!got || n != 2 || sc != 0 || d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL miss got=%b cyc=%0d stbcyc=%0d dat=%h exp 1/2/0/deadbeef", got, n, sc, d);
    end
`ifdef WB_MUX_STATS_EN
    total++;
    if (ecnt !== 16'd2 || eadr !== 32'h0000_C000) begin
      bad++; $display("FAIL miss_stats cnt=%0d adr=%h exp 2/0000c000", ecnt, eadr);
    end
`endif
  endtask

  task automatic test_abort();
    int n, sc; logic [31:0] d; logic [N-1:0] so; logic got;
    lat[1] = 1000;
    cyc = 1'b1; stb = 1'b1; adr = 32'h0000_4000;
    @(negedge clk);
    #1;
    total++;
    if (sstb !== 3'b010 || ack !== 1'b0) begin
      bad++; $display("FAIL abort_busy stb=%b ack=%b exp 010/0", sstb, ack);
    end
    @(negedge clk);
    stb = 1'b0;
    #1;
    total++;
    if (sstb !== 3'b000 || scyc !== 3'b000 || ack !== 1'b0) begin
      bad++; $display("FAIL abort_drop stb=%b cyc=%b ack=%b exp 000/000/0", sstb, scyc, ack);
    end
    @(negedge clk);
    cyc = 1'b0;
    lat[0] = 0;
    run(32'h0000_0000, n, d, sc, so, got);
    go_idle();
    total++;
    if (!got || n != 1 || d !== 32'h1111_0000) begin
      bad++; $display("FAIL abort_next got=%b cyc=%0d dat=%h exp 1/1/11110000", got, n, d);
    end
  endtask

  task automatic test_ignored_acks();
    int n, sc; logic [31:0] d; logic [N-1:0] so; logic got;
    extra = 3'b111;
    #1;
    total++;
    if (ack !== 1'b0 || dat !== 32'd0) begin
      bad++; $display("FAIL idle_ack ack=%b dat=%h exp 0/0", ack, dat);
    end
    @(negedge clk);
    extra = 3'b101;
    lat[1] = 2;
    run(32'h0000_4000, n, d, sc, so, got);
    extra = '0;
    go_idle();
    total++;
    if (!got || n != 3 || d !== 32'h2222_0000 || so !== 3'b010) begin
      bad++; $display("FAIL foreign_ack got=%b cyc=%0d dat=%h stb=%b exp 1/3/22220000/010", got, n, d, so);
    end
  endtask

  task automatic test_reset_mid();
    lat[1] = 1000;
    cyc = 1'b1; stb = 1'b1; adr = 32'h0000_4000;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sstb !== 3'b010) begin
      bad++; $display("FAIL rstmid_pre stb=%b exp 010", sstb);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({sstb, scyc, ack, dat} !== '0) begin
      bad++; $display("FAIL rstmid_async stb=%b cyc=%b ack=%b dat=%h exp all zero", sstb, scyc, ack, dat);
    end
`ifdef WB_MUX_STATS_EN
    total++;
    if (ecnt !== 16'd0) begin
      bad++; $display("FAIL rstmid_stats cnt=%0d exp 0", ecnt);
    end
`endif
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    extra[1] = 1'b1;
    #1;
    total++;
    if (ack !== 1'b0) begin
      bad++; $display("FAIL rstmid_late_ack ack=%b exp 0", ack);
    end
    @(negedge clk);
    #1;
    total++;
    if (ack !== 1'b0 || sstb !== 3'b000) begin
      bad++; $display("FAIL rstmid_late_ack2 ack=%b stb=%b exp 0/000", ack, sstb);
    end
    extra = '0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) lat[i] = 0;
    test_reset();
    test_read();
    test_back_to_back();
    test_timeout();
    test_ack_at_timeout();
    test_miss();
    test_abort();
    test_ignored_acks();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
